// File: rtl/hyper_pkg.sv
// ---------------------------------------------------------------------------
// hyper_pkg
//   Shared definitions for the LSAB-to-DRAM block mover.
//   - mvblck_state_t : state encoding of the block-move FSM
//   - LANES_PER_WORD : byte lanes carried by one DRAM word (two)
//   - lane_shift()   : bit position of a word's lanes inside a beat mask
// ---------------------------------------------------------------------------
package hyper_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_PRIME = 3'd1,
        ST_MOVE  = 3'd2,
        ST_PAUSE = 3'd3,
        ST_FLUSH = 3'd4,
        ST_FIN   = 3'd5
    } mvblck_state_t;

    localparam int LANES_PER_WORD = 2;

    // Word n inside a beat owns write-enable bits [2n+1:2n].
    function automatic int unsigned lane_shift(input int unsigned word_off);
        return word_off * LANES_PER_WORD;
    endfunction

endpackage

// File: rtl/hyper_beat_pack.sv
// ---------------------------------------------------------------------------
// hyper_beat_pack
//   Collects the words moved by the FSM into MCU beats. Each moved word sets
//   its two lanes in a running mask; the beat is issued on the cycle after
//   the word in the top slot of the beat, or the last word of the transfer,
//   is moved. A flush issues whatever partial beat is held (nothing when the
//   mask is empty).
//
//   Ports
//     clk, rst_n  : clock, asynchronous active-low reset
//     clear       : drop any held mask (start of a new transfer)
//     word_valid  : one word moved this cycle at word_addr
//     word_addr   : address of the word being moved
//     word_last   : the moved word is the final one of the transfer
//     flush       : issue the partial beat, if any
//     req         : one-cycle MCU beat request
//     coll_addr   : beat-aligned address of the issued beat
//     we          : lane write enables of the issued beat, word 0 in LSBs
//
//   Beats are aligned blocks of 2**BEAT_LOG2 words and 2**ADDR_W is a
//   multiple of that size, so a beat never spans the address wrap: the word
//   at the top address always closes its beat before the address returns
//   to zero.
// ---------------------------------------------------------------------------
module hyper_beat_pack
    import hyper_pkg::*;
#(
    parameter int BEAT_LOG2 = 1,
    parameter int ADDR_W    = 12
) (
    input  logic                                      clk,
    input  logic                                      rst_n,
    input  logic                                      clear,
    input  logic                                      word_valid,
    input  logic [ADDR_W-1:0]                         word_addr,
    input  logic                                      word_last,
    input  logic                                      flush,
    output logic                                      req,
    output logic [ADDR_W-1:0]                         coll_addr,
    output logic [LANES_PER_WORD*(2**BEAT_LOG2)-1:0]  we
);

    localparam int BEAT = 2 ** BEAT_LOG2;
    localparam int WE_W = LANES_PER_WORD * BEAT;
    localparam logic [ADDR_W-1:0] LO_MASK = ADDR_W'(BEAT - 1);

    logic [WE_W-1:0]   mask_q;
    logic [ADDR_W-1:0] base_q;
    logic [WE_W-1:0]   word_bits;
    logic [WE_W-1:0]   merged;
    logic [ADDR_W-1:0] word_base;
    logic              beat_end;

    always_comb begin
        word_base = word_addr & ~LO_MASK;
        word_bits = WE_W'({LANES_PER_WORD{1'b1}}) << lane_shift(32'(word_addr & LO_MASK));
        merged    = mask_q | word_bits;
        beat_end  = (word_addr & LO_MASK) == LO_MASK;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mask_q    <= '0;
            base_q    <= '0;
            req       <= 1'b0;
            coll_addr <= '0;
            we        <= '0;
        end else begin
            req <= 1'b0;
            if (clear) begin
                mask_q <= '0;
            end else if (word_valid) begin
                if (beat_end || word_last) begin
                    req       <= 1'b1;
                    coll_addr <= word_base;
                    we        <= merged;
                    mask_q    <= '0;
                end else begin
                    mask_q <= merged;
                    base_q <= word_base;
                end
            end else if (flush && (mask_q != '0)) begin
                req       <= 1'b1;
                coll_addr <= base_q;
                we        <= mask_q;
                mask_q    <= '0;
            end
        end
    end

endmodule

// File: rtl/hyper_mvblck_todram_p.sv
// ---------------------------------------------------------------------------
// hyper_mvblck_todram_p
//   Moves COUNT_REQ words from one LSAB section into DRAM starting at
//   START_ADDRESS (any alignment), packing them into MCU beats of
//   2**BEAT_LOG2 words with per-lane write enables.
//
//   Optional feature: HYPER_MVBLCK_RESUME_EN. When defined, an LSAB stop
//   during the move parks the FSM in PAUSE (mask kept) for up to WAIT_LIMIT
//   cycles and resumes if the section refills. When undefined, a stop ends
//   the transfer through FLUSH and no pause counter exists.
//
//   Ports
//     CLK, RST            : clock, asynchronous active-low reset
//     LSAB_STOP           : per-section empty/stop flags
//     LSAB_READ           : pop request to the selected section
//     LSAB_SECTION        : selected section
//     START_ADDRESS       : first word address
//     COUNT_REQ           : number of words requested
//     SECTION             : section for the transfer
//     ISSUE               : start pulse, honoured in IDLE only
//     ABORT               : stop after the word moving this cycle
//     COUNT_SENT          : words written by the last transfer
//     WORKING             : busy, one cycle behind the FSM
//     DONE                : one-cycle completion pulse
//     MCU_COLL_ADDRESS    : beat-aligned address of a beat request
//     MCU_WE_ARRAY        : lane write enables of a beat request
//     MCU_REQUEST_ACCESS  : one-cycle beat request
//     DBG_STATE           : current FSM state (mvblck_state_t encoding)
//
//   LSAB handshake: a word leaves the section on a rising edge where
//   LSAB_READ=1 and LSAB_STOP[LSAB_SECTION]=0; LSAB_READ is the "ready"
//   side and the negated stop flag is the "valid" side. A high stop with
//   LSAB_READ=1 moves nothing.
// ---------------------------------------------------------------------------
module hyper_mvblck_todram_p
    import hyper_pkg::*;
#(
    parameter int ADDR_W     = 12,
    parameter int CNT_W      = 6,
    parameter int NSECT      = 4,
    parameter int BEAT_LOG2  = 1,
    parameter int WAIT_LIMIT = 15,
    localparam int SECT_W    = (NSECT > 1) ? $clog2(NSECT) : 1
) (
    input  logic                                      CLK,
    input  logic                                      RST,
    input  logic [NSECT-1:0]                          LSAB_STOP,
    output logic                                      LSAB_READ,
    output logic [SECT_W-1:0]                         LSAB_SECTION,
    input  logic [ADDR_W-1:0]                         START_ADDRESS,
    input  logic [CNT_W-1:0]                          COUNT_REQ,
    input  logic [SECT_W-1:0]                         SECTION,
    input  logic                                      ISSUE,
    input  logic                                      ABORT,
    output logic [CNT_W-1:0]                          COUNT_SENT,
    output logic                                      WORKING,
    output logic                                      DONE,
    output logic [ADDR_W-1:0]                         MCU_COLL_ADDRESS,
    output logic [LANES_PER_WORD*(2**BEAT_LOG2)-1:0]  MCU_WE_ARRAY,
    output logic                                      MCU_REQUEST_ACCESS,
    output logic [2:0]                                DBG_STATE
);

    mvblck_state_t     state_q;
    logic [ADDR_W-1:0] addr_q;
    logic [CNT_W-1:0]  remain_q;
    logic [CNT_W-1:0]  count_req_q;
    logic [SECT_W-1:0] sect_q;
    logic              lsab_read_q;
    logic [CNT_W-1:0]  count_sent_q;
    logic              working_q;
    logic              done_q;

`ifdef HYPER_MVBLCK_RESUME_EN
    localparam int WAIT_W = $clog2(WAIT_LIMIT + 1);
    logic [WAIT_W-1:0] wait_q;
`endif

    logic stop_sel;
    logic xfer;
    logic last_word;
    logic pack_clear;
    logic pack_flush;

    always_comb begin
        stop_sel   = LSAB_STOP[sect_q];
        xfer       = (state_q == ST_MOVE) && lsab_read_q && !stop_sel;
        last_word  = xfer && (remain_q == CNT_W'(1));
        pack_clear = (state_q == ST_IDLE) && ISSUE;
        pack_flush = (state_q == ST_FLUSH);
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q      <= ST_IDLE;
            addr_q       <= '0;
            remain_q     <= '0;
            count_req_q  <= '0;
            sect_q       <= '0;
            lsab_read_q  <= 1'b0;
            count_sent_q <= '0;
            working_q    <= 1'b0;
            done_q       <= 1'b0;
`ifdef HYPER_MVBLCK_RESUME_EN
            wait_q       <= '0;
`endif
        end else begin
            done_q    <= 1'b0;
            working_q <= (state_q != ST_IDLE);

            case (state_q)
                ST_IDLE: begin
                    lsab_read_q <= 1'b0;
                    if (ISSUE) begin
                        sect_q      <= SECTION;
                        addr_q      <= START_ADDRESS;
                        remain_q    <= COUNT_REQ;
                        count_req_q <= COUNT_REQ;
                        state_q     <= (COUNT_REQ == '0) ? ST_FIN : ST_PRIME;
                    end
                end

                // Do not pop until the section holds data; an empty
                // section at issue time must not count as a stop.
                ST_PRIME: begin
                    if (ABORT) begin
                        state_q <= ST_FIN;
                    end else if (!stop_sel) begin
                        lsab_read_q <= 1'b1;
                        state_q     <= ST_MOVE;
                    end
                end

                ST_MOVE: begin
                    if (xfer) begin
                        addr_q   <= addr_q + ADDR_W'(1);
                        remain_q <= remain_q - CNT_W'(1);
                    end
                    if (last_word) begin
                        lsab_read_q <= 1'b0;
                        state_q     <= ST_FIN;
                    end else if (ABORT) begin
                        // The word moving this cycle (if any) still counts.
                        lsab_read_q <= 1'b0;
                        state_q     <= ST_FLUSH;
                    end else if (stop_sel) begin
                        lsab_read_q <= 1'b0;
`ifdef HYPER_MVBLCK_RESUME_EN
                        wait_q      <= '0;
                        state_q     <= ST_PAUSE;
`else
                        state_q     <= ST_FLUSH;
`endif
                    end
                end

`ifdef HYPER_MVBLCK_RESUME_EN
                ST_PAUSE: begin
                    if (ABORT) begin
                        state_q <= ST_FLUSH;
                    end else if (!stop_sel) begin
                        lsab_read_q <= 1'b1;
                        state_q     <= ST_MOVE;
                    end else if (wait_q == WAIT_W'(WAIT_LIMIT - 1)) begin
                        state_q <= ST_FLUSH;
                    end else begin
                        wait_q <= wait_q + WAIT_W'(1);
                    end
                end
`endif

                // The beat packer issues the partial beat on this edge.
                ST_FLUSH: begin
                    state_q <= ST_FIN;
                end

                ST_FIN: begin
                    count_sent_q <= count_req_q - remain_q;
                    done_q       <= 1'b1;
                    state_q      <= ST_IDLE;
                end

                default: begin
                    lsab_read_q <= 1'b0;
                    state_q     <= ST_IDLE;
                end
            endcase
        end
    end

    hyper_beat_pack #(
        .BEAT_LOG2 (BEAT_LOG2),
        .ADDR_W    (ADDR_W)
    ) u_beat_pack (
        .clk        (CLK),
        .rst_n      (RST),
        .clear      (pack_clear),
        .word_valid (xfer),
        .word_addr  (addr_q),
        .word_last  (last_word),
        .flush      (pack_flush),
        .req        (MCU_REQUEST_ACCESS),
        .coll_addr  (MCU_COLL_ADDRESS),
        .we         (MCU_WE_ARRAY)
    );

    assign LSAB_READ    = lsab_read_q;
    assign LSAB_SECTION = sect_q;
    assign COUNT_SENT   = count_sent_q;
    assign WORKING      = working_q;
    assign DONE         = done_q;
    assign DBG_STATE    = state_q;

endmodule
